// File: rtl/serial_to_parallel.sv
// Serial-to-parallel deserializer with a one-entry ready/valid output register.
// Define S2P_MSB_FIRST_EN to make the first serial bit land in dout[DATA_WIDTH-1].
module serial_to_parallel #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  din,
  input  logic                  din_valid,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  dout_valid,
  input  logic                  dout_ready,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overflow
);

  localparam int CW = $clog2(DATA_WIDTH) + 1;
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_WIDTH - 1);

  typedef enum logic {IDLE, SHIFT} state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d, shift_in;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  dout_valid_q, dout_valid_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overflow_q, overflow_d;
  logic                  word_done;

`ifdef S2P_MSB_FIRST_EN
  assign shift_in = {shift_q[DATA_WIDTH-2:0], din};
`else
  assign shift_in = {din, shift_q[DATA_WIDTH-1:1]};
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values of its neighbours.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // NOTE: every variable gets a default first so no path infers a latch.
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    shift_d     = shift_q;
    word_done   = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (din_valid) begin
          shift_d = shift_in;
          count_d = CW'(1);
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (din_valid) begin
          shift_d = shift_in;
          if (count_q == LAST_BIT) begin
            count_d   = '0;
            state_d   = IDLE;
            word_done = 1'b1;
          end else begin
            count_d = count_q + CW'(1);
          end
        end else begin
          count_d     = '0;
          state_d     = IDLE;
          frame_err_d = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A completed word replaces the held one only if the slot is empty or draining now.
  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overflow_d   = 1'b0;
    if (word_done) begin
      if (!dout_valid_q || dout_ready) begin
        dout_d       = shift_in;
        dout_valid_d = 1'b1;
      end else begin
        overflow_d = 1'b1;
      end
    end else if (dout_valid_q && dout_ready) begin
      dout_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q      <= '0;
      shift_q      <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      frame_err_q  <= 1'b0;
      overflow_q   <= 1'b0;
    end else begin
      count_q      <= count_d;
      shift_q      <= shift_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      frame_err_q  <= frame_err_d;
      overflow_q   <= overflow_d;
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q == SHIFT);
  assign frame_err  = frame_err_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_serial_to_parallel.sv
// Self-checking bench for serial_to_parallel: directed scenarios plus random
// bursts compared against a word-level reference model.
module tb_serial_to_parallel;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         din = 1'b0;
  logic         din_valid = 1'b0;
  logic         dout_ready = 1'b0;
  logic [W-1:0] dout;
  logic         dout_valid, busy, frame_err, overflow;

  int errors = 0;
  int checks = 0;

  // Reference model state: bits gathered so far and the output slot.
  int           m_cnt;
  logic [W-1:0] m_acc;
  logic [W-1:0] m_dout;
  logic         m_valid, m_fe, m_ov;

  always #5 clk = ~clk;

  serial_to_parallel #(.DATA_WIDTH(W)) dut (
    .clk        (clk),
    .rst        (rst),
    .din        (din),
    .din_valid  (din_valid),
    .dout       (dout),
    .dout_valid (dout_valid),
    .dout_ready (dout_ready),
    .busy       (busy),
    .frame_err  (frame_err),
    .overflow   (overflow)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
    end
  endtask

  // Word a serializer streaming w LSB-first turns into in this build.
  function automatic logic [W-1:0] expect_word(input logic [W-1:0] w);
    logic [W-1:0] r;
`ifdef S2P_MSB_FIRST_EN
    for (int i = 0; i < W; i++) r[W-1-i] = w[i];
`else
    r = w;
`endif
    return r;
  endfunction

  task automatic model_reset();
    m_cnt = 0; m_acc = '0; m_dout = '0; m_valid = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
  endtask

  task automatic check_all(input string tag);
    check({tag, ".dout"},       32'(dout),       32'(m_dout));
    check({tag, ".dout_valid"}, 32'(dout_valid), 32'(m_valid));
    check({tag, ".busy"},       32'(busy),       32'(m_cnt > 0));
    check({tag, ".frame_err"},  32'(frame_err),  32'(m_fe));
    check({tag, ".overflow"},   32'(overflow),   32'(m_ov));
  endtask

  // One clock: apply inputs, advance the model on the edge, compare 1 ns later.
  task automatic step(input logic d, input logic dv, input logic rdy, input string tag);
    logic done;
    int   pos;
    din = d; din_valid = dv; dout_ready = rdy;
    @(posedge clk);
    done = 1'b0; m_fe = 1'b0; m_ov = 1'b0;
    if (dv) begin
      if (m_cnt == 0) m_acc = '0;
`ifdef S2P_MSB_FIRST_EN
      pos = W - 1 - m_cnt;
`else
      pos = m_cnt;
`endif
      m_acc[pos] = d;
      m_cnt++;
      if (m_cnt == W) begin
        done  = 1'b1;
        m_cnt = 0;
      end
    end else if (m_cnt > 0) begin
      m_fe  = 1'b1;
      m_cnt = 0;
    end
    if (done) begin
      if (!m_valid || rdy) begin
        m_dout  = m_acc;
        m_valid = 1'b1;
      end else begin
        m_ov = 1'b1;
      end
    end else if (m_valid && rdy) begin
      m_valid = 1'b0;
    end
    #1;
    check_all(tag);
  endtask

  // Stream w LSB-first; dout_ready is rdy_body for all bits but the last.
  task automatic send_word(input logic [W-1:0] w, input logic rdy_body, input logic rdy_last,
                           input string tag);
    for (int i = 0; i < W; i++)
      step(w[i], 1'b1, (i == W - 1) ? rdy_last : rdy_body, tag);
  endtask

  initial begin
    model_reset();
    #12;
    check("reset.dout",       32'(dout),       32'h0);
    check("reset.dout_valid", 32'(dout_valid), 32'h0);
    check("reset.busy",       32'(busy),       32'h0);
    check("reset.flags",      32'({frame_err, overflow}), 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // LSB-first word 0xA5, one-cycle dout_valid.
    step(1'b1, 1'b1, 1'b1, "a5.bit1");
    check("a5.busy_bit2", 32'(busy), 32'h1);
    send_word(8'hA5 >> 1 | 8'h80, 1'b1, 1'b1, "a5.fill");
    step(1'b0, 1'b0, 1'b1, "a5.idle");
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, 1'b1, "a5.flush");
    send_word(8'hA5, 1'b1, 1'b1, "a5");
    check("a5.dout",  32'(dout),       32'(expect_word(8'hA5)));
    check("a5.valid", 32'(dout_valid), 32'h1);
    check("a5.busy",  32'(busy),       32'h0);
    step(1'b0, 1'b0, 1'b1, "a5.drain");
    check("a5.valid_gone", 32'(dout_valid), 32'h0);

    // Back-to-back 0x3C then 0xC3.
    send_word(8'h3C, 1'b1, 1'b1, "b2b1");
    check("b2b.first", 32'(dout), 32'(expect_word(8'h3C)));
    send_word(8'hC3, 1'b1, 1'b1, "b2b2");
    check("b2b.second", 32'(dout), 32'(expect_word(8'hC3)));
    step(1'b0, 1'b0, 1'b1, "b2b.drain");

    // Backpressure and overflow.
    send_word(8'h11, 1'b0, 1'b0, "ovf1");
    send_word(8'h22, 1'b0, 1'b0, "ovf2");
    check("ovf.pulse", 32'(overflow), 32'h1);
    check("ovf.kept",  32'(dout),     32'(expect_word(8'h11)));
    step(1'b0, 1'b0, 1'b0, "ovf.hold");
    check("ovf.once",  32'(overflow), 32'h0);
    step(1'b0, 1'b0, 1'b1, "ovf.accept");
    check("ovf.accept_valid", 32'(dout_valid), 32'h0);
    check("ovf.accept_dout",  32'(dout),       32'(expect_word(8'h11)));

    // Accept on the edge that completes the next word.
    send_word(8'h11, 1'b0, 1'b0, "sim1");
    send_word(8'h22, 1'b0, 1'b1, "sim2");
    check("sim.dout",  32'(dout),       32'(expect_word(8'h22)));
    check("sim.valid", 32'(dout_valid), 32'h1);
    check("sim.ovf",   32'(overflow),   32'h0);
    step(1'b0, 1'b0, 1'b1, "sim.drain");

    // Framing error after 5 bits, then a clean 0x5A.
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b1, "fe.bits");
    step(1'b1, 1'b0, 1'b1, "fe.cut");
    check("fe.pulse", 32'(frame_err),  32'h1);
    check("fe.busy",  32'(busy),       32'h0);
    check("fe.valid", 32'(dout_valid), 32'h0);
    step(1'b0, 1'b0, 1'b1, "fe.after");
    check("fe.once", 32'(frame_err), 32'h0);
    send_word(8'h5A, 1'b1, 1'b1, "fe.next");
    check("fe.next_dout", 32'(dout), 32'(expect_word(8'h5A)));

    // Reset in the middle of a word.
    for (int i = 0; i < 3; i++) step(1'b1, 1'b1, 1'b1, "rst.bits");
    rst = 1'b1;
    #1;
    check("rst.mid_dout",  32'(dout),       32'h0);
    check("rst.mid_other", 32'({dout_valid, busy, frame_err, overflow}), 32'h0);
    model_reset();
    din_valid = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    send_word(8'h01, 1'b1, 1'b1, "rst.word");
`ifdef S2P_MSB_FIRST_EN
    check("rst.word_dout", 32'(dout), 32'h80);
`else
    check("rst.word_dout", 32'(dout), 32'h01);
`endif
    step(1'b0, 1'b0, 1'b1, "rst.drain");

    // Random bursts: full, truncated or idle, with random backpressure.
    for (int n = 0; n < 300; n++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 9));
      if (kind < 6)      len = W;
      else if (kind < 8) len = int'($urandom_range(1, W - 1));
      else               len = 0;
      for (int i = 0; i < len; i++)
        step(1'($urandom), 1'b1, 1'($urandom_range(0, 3) != 0), "rnd.bit");
      if (len != W || $urandom_range(0, 1) == 0)
        step(1'($urandom), 1'b0, 1'($urandom), "rnd.gap");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
